// File: rtl/controller_iram_loader_pkg.sv
// Shared types and constants for the IRAM loader.
package controller_iram_loader_pkg;

    localparam int         DEF_ADDR_W    = 14;
    localparam int         DEF_NUM_WORDS = 10240;
    localparam logic [3:0] BYTE_EN_ALL   = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        READ,
        CHECK,
        FIN
    } state_t;

endpackage

// File: rtl/controller_iram_byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
module controller_iram_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] cnt;

    // The fourth accepted byte completes the word.
    assign last = take && (cnt == 2'd3);

    // Byte lane fill; clear drops any partially assembled word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
        end else if (take) begin
            case (cnt)
                2'd0:    word[7:0]   <= in_data;
                2'd1:    word[15:8]  <= in_data;
                2'd2:    word[23:16] <= in_data;
                default: word[31:24] <= in_data;
            endcase
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/controller_iram_loader.sv
// Loads a byte stream into a word RAM, reads it back and verifies a sum.
module controller_iram_loader
    import controller_iram_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_debugaccess,
    output logic              avm_clken,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] ONE = 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   index;
    logic [ADDR_W:0]   rd_idx;
    logic [ADDR_W:0]   cap_cnt;
    logic [31:0]       sum_w;
    logic [31:0]       sum_r;
    logic [RD_LAT-1:0] vld_pipe;
    logic [31:0]       end_addr;
    logic              range_err;
    logic              accept;
    logic              issue;
    logic              capture;
    logic              wr_last;
    logic              cap_last;
    logic [31:0]       pk_word;
    logic              pk_last;

    // Range check is done 32 bits wide so base+count can never wrap.
    assign end_addr  = 32'(base_addr) + 32'(word_count);
    assign range_err = end_addr > 32'(NUM_WORDS);
    assign accept    = (state == IDLE) && start;
    assign issue     = (state == READ) && (rd_idx < count_r);
    assign capture   = vld_pipe[RD_LAT-1];
    assign wr_last   = (index + ONE) == count_r;
    assign cap_last  = (cap_cnt + ONE) == count_r;

    controller_iram_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .take    (in_valid && (state == FILL)),
        .in_data (in_data),
        .word    (pk_word),
        .last    (pk_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; READ waits until every issued read has been captured.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) begin
                       if (word_count == '0 || range_err) state_next = FIN;
                       else                               state_next = FILL;
                   end
            FILL:  if (pk_last) state_next = WRITE;
            WRITE: state_next = wr_last ? READ : FILL;
            READ:  if (capture && cap_last) state_next = CHECK;
            CHECK: state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        in_ready        = 1'b0;
        avm_address     = '0;
        avm_chipselect  = 1'b0;
        avm_write       = 1'b0;
        avm_debugaccess = 1'b0;
        avm_clken       = 1'b1;
        avm_byteenable  = 4'h0;
        avm_writedata   = '0;
        done            = 1'b0;
        busy            = (state == FILL) || (state == WRITE) ||
                          (state == READ) || (state == CHECK);
        case (state)
            FILL:  in_ready = 1'b1;
            WRITE: begin
                avm_chipselect  = 1'b1;
                avm_write       = 1'b1;
                avm_debugaccess = 1'b1;
                avm_byteenable  = BYTE_EN_ALL;
                avm_address     = base_r + index[ADDR_W-1:0];
                avm_writedata   = pk_word;
            end
            READ:  if (issue) begin
                avm_chipselect  = 1'b1;
                avm_byteenable  = BYTE_EN_ALL;
                avm_address     = base_r + rd_idx[ADDR_W-1:0];
            end
            FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Read-latency tracker: a set bit marks readdata for an issued address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Load context, indices, running sums and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r   <= '0;
            count_r  <= '0;
            index    <= '0;
            rd_idx   <= '0;
            cap_cnt  <= '0;
            sum_w    <= '0;
            sum_r    <= '0;
            error    <= 1'b0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_r   <= base_addr;
                    count_r  <= word_count;
                    index    <= '0;
                    rd_idx   <= '0;
                    cap_cnt  <= '0;
                    sum_w    <= '0;
                    sum_r    <= '0;
                    checksum <= '0;
                    error    <= (word_count != '0) && range_err;
                end
                WRITE: begin
                    sum_w <= sum_w + pk_word;
                    index <= index + ONE;
                end
                READ: begin
                    if (issue) rd_idx <= rd_idx + ONE;
                    if (capture) begin
                        sum_r   <= sum_r + avm_readdata;
                        cap_cnt <= cap_cnt + ONE;
                    end
                end
                CHECK: begin
                    if (sum_r != sum_w) error <= 1'b1;
                    checksum <= sum_w;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_iram_loader.sv
// Directed bench: RAM model, scenario tasks with inline checks.
module tb_controller_iram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] avm_address;
    logic        avm_chipselect, avm_write, avm_debugaccess, avm_clken;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        busy, done, error;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:10239];
    logic [13:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [13:0] ra_q[$];
    int          cs_cnt = 0;
    int          done_cnt = 0;
    bit          corrupt_en = 1'b0;
    logic [13:0] corrupt_addr = 14'd1;
    logic [7:0]  bytes_q[$];

    controller_iram_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_debugaccess (avm_debugaccess),
        .avm_clken       (avm_clken),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle read latency, optional readback corruption.
    always @(posedge clk) begin
        if (avm_chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (avm_write) begin
                mem[avm_address] <= avm_writedata;
                wa_q.push_back(avm_address);
                wd_q.push_back(avm_writedata);
            end else begin
                ra_q.push_back(avm_address);
                avm_readdata <= mem[avm_address] ^
                    ((corrupt_en && avm_address == corrupt_addr) ? 32'h0000_00FF : 32'h0);
            end
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Pulses start, returning one negedge later.
    task automatic do_start(input logic [13:0] b, input logic [14:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds queued bytes and waits for done, optionally toggling valid and
    // pulsing a stray start at cycle restart_cyc.
    task automatic run_load(input bit toggle, input int restart_cyc, input int budget,
                            output bit got, output logic e, output logic [31:0] ck);
        int cyc = 0;
        got = 1'b0; e = 1'b0; ck = '0;
        while (cyc < budget) begin
            if (done) begin
                got = 1'b1; e = error; ck = checksum;
                break;
            end
            start = (cyc == restart_cyc);
            if (start) begin base_addr = 14'd0; word_count = 15'd1; end
            in_valid = 1'b0; in_data = 8'h00;
            if (in_ready && bytes_q.size() > 0) begin
                if (!toggle || cyc[0]) begin
                    in_valid = 1'b1; in_data = bytes_q.pop_front();
                end
            end else if (toggle && cyc[0]) begin
                in_valid = 1'b1; in_data = 8'hEE;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, in_ready, avm_chipselect, avm_write, avm_debugaccess} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {busy, done, error, in_ready, avm_chipselect, avm_write, avm_debugaccess});
        end
        checks++;
        if (checksum !== 32'h0) begin
            errors++; $display("FAIL reset_checksum: got %h expected 00000000", checksum);
        end
        checks++;
        if (avm_clken !== 1'b1) begin
            errors++; $display("FAIL reset_clken: got %b expected 1", avm_clken);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit got; logic e; logic [31:0] ck;
        int w0 = wa_q.size(); int r0 = ra_q.size();
        bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_start(14'd0, 15'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        run_load(1'b0, -1, 100, got, e, ck);
        checks++;
        if (!got) begin errors++; $display("FAIL basic_done: got timeout expected done"); end
        checks++;
        if (e !== 1'b0 || ck !== 32'h0C0A0806) begin
            errors++; $display("FAIL basic_result: got err=%b sum=%h expected err=0 sum=0c0a0806", e, ck);
        end
        checks++;
        if (wa_q.size() - w0 != 2 || wa_q[w0] !== 14'd0 || wd_q[w0] !== 32'h04030201 ||
            wa_q[w0+1] !== 14'd1 || wd_q[w0+1] !== 32'h08070605) begin
            errors++; $display("FAIL basic_writes: got n=%0d expected 2 writes 04030201@0 08070605@1",
                wa_q.size() - w0);
        end
        checks++;
        if (ra_q.size() - r0 != 2 || ra_q[r0] !== 14'd0 || ra_q[r0+1] !== 14'd1) begin
            errors++; $display("FAIL basic_reads: got n=%0d expected reads of 0,1", ra_q.size() - r0);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || checksum !== 32'h0C0A0806) begin
            errors++; $display("FAIL basic_hold: got done=%b sum=%h expected done=0 sum=0c0a0806", done, checksum);
        end
    endtask

    task automatic test_zero_count();
        int c0 = cs_cnt;
        do_start(14'd3, 15'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b err=%b expected 1 0 0", done, busy, error);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cs_cnt != c0) begin errors++; $display("FAIL zero_nobus: got %0d cs expected 0", cs_cnt - c0); end
    endtask

    task automatic test_bounds();
        bit got; logic e; logic [31:0] ck;
        int c0 = cs_cnt; int w0;
        do_start(14'd10239, 15'd2);
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            errors++; $display("FAIL bound_over: got done=%b err=%b expected 1 1", done, error);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cs_cnt != c0) begin errors++; $display("FAIL bound_nobus: got %0d cs expected 0", cs_cnt - c0); end
        w0 = wa_q.size();
        bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_start(14'd10239, 15'd1);
        run_load(1'b0, -1, 100, got, e, ck);
        checks++;
        if (!got || e !== 1'b0 || ck !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL bound_last: got done=%b err=%b sum=%h expected 1 0 ddccbbaa", got, e, ck);
        end
        checks++;
        if (wa_q.size() - w0 != 1 || wa_q[w0] !== 14'd10239 || wd_q[w0] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL bound_write: got n=%0d expected one write ddccbbaa@10239", wa_q.size() - w0);
        end
        @(negedge clk);
    endtask

    task automatic test_corrupt();
        bit got; logic e; logic [31:0] ck;
        corrupt_en = 1'b1;
        bytes_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        do_start(14'd0, 15'd2);
        run_load(1'b0, -1, 100, got, e, ck);
        checks++;
        if (!got || e !== 1'b1 || ck !== 32'h2C2A2826) begin
            errors++; $display("FAIL corrupt_err: got done=%b err=%b sum=%h expected 1 1 2c2a2826", got, e, ck);
        end
        corrupt_en = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL corrupt_sticky: got %b expected 1", error); end
        bytes_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        do_start(14'd2, 15'd1);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL corrupt_clear: got %b expected 0", error); end
        run_load(1'b0, -1, 100, got, e, ck);
        checks++;
        if (!got || e !== 1'b0) begin
            errors++; $display("FAIL corrupt_next: got done=%b err=%b expected 1 0", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got; logic e; logic [31:0] ck;
        int w0 = wa_q.size(); int c0;
        bytes_q = '{8'h55, 8'h66};
        do_start(14'd0, 15'd1);
        run_load(1'b0, -1, 4, got, e, ck);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, in_ready, avm_chipselect, avm_write, avm_debugaccess} !== 7'b0 ||
            checksum !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs: got ctrl=%b sum=%h expected 0",
                {busy, done, error, in_ready, avm_chipselect, avm_write, avm_debugaccess}, checksum);
        end
        c0 = cs_cnt;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_cnt != c0 || wa_q.size() != w0) begin
            errors++; $display("FAIL midrst_nobus: got %0d writes expected 0", wa_q.size() - w0);
        end
        bytes_q = '{8'h21, 8'h22, 8'h23, 8'h24};
        do_start(14'd5, 15'd1);
        run_load(1'b0, -1, 100, got, e, ck);
        checks++;
        if (!got || wa_q.size() - w0 != 1 || wa_q[w0] !== 14'd5 || wd_q[w0] !== 32'h24232221) begin
            errors++; $display("FAIL midrst_reload: got done=%b n=%0d expected one write 24232221@5",
                got, wa_q.size() - w0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit got; logic e; logic [31:0] ck;
        int w0 = wa_q.size(); int d0 = done_cnt;
        bytes_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                    8'h37, 8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C};
        do_start(14'd100, 15'd3);
        run_load(1'b1, 5, 200, got, e, ck);
        checks++;
        if (!got || e !== 1'b0 || ck !== 32'hA8A5A29F) begin
            errors++; $display("FAIL b2b_result: got done=%b err=%b sum=%h expected 1 0 a8a5a29f", got, e, ck);
        end
        checks++;
        if (wa_q.size() - w0 != 3 || wa_q[w0] !== 14'd100 || wd_q[w0] !== 32'h34333231 ||
            wa_q[w0+1] !== 14'd101 || wd_q[w0+1] !== 32'h38373635 ||
            wa_q[w0+2] !== 14'd102 || wd_q[w0+2] !== 32'h3C3B3A39) begin
            errors++; $display("FAIL b2b_writes: got n=%0d expected 3 writes at 100..102", wa_q.size() - w0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_single_done: got %0d pulses busy=%b expected 1 pulse busy=0",
                done_cnt - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_bounds();
        test_corrupt();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_iram_loader.md
CONTROLLER_IRAM_LOADER -- requirements
Module: controller_iram_loader

Interface
REQ-001 Parameter ADDR_W, default 14, word address width of the target RAM port.
REQ-002 Parameter NUM_WORDS, default 10240, number of addressable 32-bit words in the target RAM.
REQ-003 Parameter RD_LAT, default 1, cycles from read address presented to avm_readdata valid.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle load request; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first word address, sampled with start.
REQ-008 word_count  in  ADDR_W+1  words to load, sampled with start.
REQ-009 in_data  in  8  byte stream, little-endian within each word.
REQ-010 in_valid / in_ready  in / out  1 / 1  stream handshake; a byte transfers when both are high.
REQ-011 avm_address  out  ADDR_W  RAM word address.
REQ-012 avm_chipselect, avm_write, avm_debugaccess, avm_clken  out  1 each  RAM slave controls.
REQ-013 avm_byteenable  out  4  byte lanes.
REQ-014 avm_writedata / avm_readdata  out / in  32 / 32  RAM data.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 error  out  1  sticky fault flag, cleared by the next accepted start.
REQ-018 checksum  out  32  mod-2^32 sum of written words, held after done.

Function
REQ-019 FSM states SHALL be IDLE, FILL, WRITE, READ, CHECK, FIN.
REQ-020 IDLE + start: if word_count==0 -> FIN with no bus cycle; if base_addr+word_count > NUM_WORDS -> FIN with error=1 and no bus cycle; otherwise -> FILL.
REQ-021 FILL: in_ready=1; collect 4 bytes, first byte into [7:0]; after the 4th byte -> WRITE next cycle.
REQ-022 WRITE: exactly one cycle with avm_chipselect=avm_write=avm_debugaccess=1, byteenable=4'hF, address=base+index; add word to sum_w; index+1; -> FILL, or -> READ after the last word.
REQ-023 in_ready SHALL be 0 in every state except FILL.
REQ-024 READ: issue one read per cycle (chipselect=1, write=0) for addresses base..base+count-1; capture avm_readdata RD_LAT cycles after each address; accumulate into sum_r.
REQ-025 After the last capture -> CHECK; if sum_r != sum_w then set error=1; -> FIN.
REQ-026 FIN: done=1 for one cycle, busy=0, checksum=sum_w, -> IDLE.
REQ-027 avm_clken SHALL be 1 in every state.
REQ-028 start while busy SHALL be ignored; in_valid outside FILL SHALL be ignored.
REQ-029 The last legal address (NUM_WORDS-1) SHALL be writable; address arithmetic SHALL never wrap.

Reset
REQ-030 Reset SHALL force IDLE and set busy, done, error, in_ready, avm_chipselect, avm_write and avm_debugaccess to 0, and checksum, sums and index to 0.
REQ-031 Reset mid-load SHALL abort immediately with no further bus cycle; any partially assembled word is discarded.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the NUM_WORDS/ADDR_W defaults and the byteenable constant 4'hF.
REQ-033 The byte-to-word assembler SHALL be one sub-module, controller_iram_byte_packer.

Verification
REQ-034 base=0, count=2, bytes 01..08 -> writes 0x04030201@0 and 0x08070605@1, then reads of 0 and 1, done with error=0 and checksum=0x0C0A0806.
REQ-035 count=0 + start -> done on the second cycle, no chipselect at any time, error=0.
REQ-036 base=10239, count=2 -> done with error=1 and no bus cycle; base=10239, count=1 -> one write, error=0.
REQ-037 RAM model corrupts readback of word 1 -> done with error=1; next start clears error.
REQ-038 Reset asserted after 2 bytes of word 0 -> outputs at reset values; new load from base=5 writes only the new data.
REQ-039 in_valid toggling 50% plus a second start while busy -> correct words written, second start ignored, one done pulse.
